// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared types and defaults for the run controller and its memory mux.
`default_nettype none

package run_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RST  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RST  = S_RST,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_HOST = 2'd0,
    OWN_CORE = 2'd1,
    OWN_NONE = 2'd2
  } owner_t;

  localparam int DEF_AW      = 8;
  localparam int DEF_CW      = 16;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_MAX_CYC = 4096;

  // The core only touches memory while running; RST keeps both sides off the port.
  function automatic owner_t state_owner(input state_t s);
    case (s)
      ST_RUN:  return OWN_CORE;
      ST_RST:  return OWN_NONE;
      default: return OWN_HOST;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_port_mux.sv
// dmem_port_mux: owner-selected drive of the single data-memory port.
`default_nettype none

module dmem_port_mux
  import run_ctrl_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  owner_t         i_owner,
  input  logic           i_host_req,
  input  logic           i_host_we,
  input  logic [AW-1:0]  i_host_addr,
  input  logic [7:0]     i_host_wdata,
  input  logic           i_core_we,
  input  logic [AW-1:0]  i_core_addr,
  input  logic [7:0]     i_core_wdata,
  output logic           o_mem_we,
  output logic [AW-1:0]  o_mem_addr,
  output logic [7:0]     o_mem_wdata,
  output logic           o_host_gnt
);

  always_comb begin
    o_mem_addr  = i_host_addr;
    o_mem_wdata = i_host_wdata;
    o_mem_we    = 1'b0;
    o_host_gnt  = 1'b0;
    case (i_owner)
      OWN_HOST: begin
        o_mem_we   = i_host_req & i_host_we;
        o_host_gnt = i_host_req;
      end
      OWN_CORE: begin
        o_mem_addr  = i_core_addr;
        o_mem_wdata = i_core_wdata;
        o_mem_we    = i_core_we;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/run_ctrl.sv
// run_ctrl: sequences core reset/run around a host-preloaded data memory and reports status.
`default_nettype none

module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int CW      = DEF_CW,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int MAX_CYC = DEF_MAX_CYC
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_host_start,
  input  logic           i_host_req,
  input  logic           i_host_we,
  input  logic [AW-1:0]  i_host_addr,
  input  logic [7:0]     i_host_wdata,
  output logic           o_host_gnt,
  output logic           o_host_rvalid,
  output logic [7:0]     o_host_rdata,
  output logic           o_core_rst,
  output logic           o_core_run,
  input  logic           i_core_done,
  input  logic           i_core_mem_we,
  input  logic [AW-1:0]  i_core_mem_addr,
  input  logic [7:0]     i_core_mem_wdata,
  output logic           o_mem_we,
  output logic [AW-1:0]  o_mem_addr,
  output logic [7:0]     o_mem_wdata,
  input  logic [7:0]     i_mem_rdata,
  output logic           o_busy,
  output logic           o_finished,
  output logic           o_timeout,
  output logic [CW-1:0]  o_cycle_count
);

  localparam int            RW         = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RW-1:0] c_RST_LAST = RW'(RST_CYC - 1);
  localparam logic [CW-1:0] c_MAX      = CW'(MAX_CYC);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_rst_cnt;
  logic [CW-1:0]   r_cycle_count;
  logic [CW-1:0]   w_count_inc;
  logic            w_limit;
  logic            r_timeout;
  logic            r_rvalid;
  logic [7:0]      r_rdata;
  logic            w_host_gnt;
  logic            w_rd_gnt;
  owner_t          w_owner;

  assign w_owner     = state_owner(r_state);
  assign w_rd_gnt    = w_host_gnt & ~i_host_we;
  assign w_count_inc = (r_cycle_count == c_MAX) ? r_cycle_count : r_cycle_count + 1'b1;
  assign w_limit     = (w_count_inc == c_MAX);

  dmem_port_mux #(.AW(AW)) u_mux (
    .i_owner      (w_owner),
    .i_host_req   (i_host_req),
    .i_host_we    (i_host_we),
    .i_host_addr  (i_host_addr),
    .i_host_wdata (i_host_wdata),
    .i_core_we    (i_core_mem_we),
    .i_core_addr  (i_core_mem_addr),
    .i_core_wdata (i_core_mem_wdata),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_host_gnt   (w_host_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_host_start) w_state_nxt = ST_RST;
      ST_RST:  if (r_rst_cnt == c_RST_LAST) w_state_nxt = ST_RUN;
      ST_RUN:  if (i_core_done || w_limit) w_state_nxt = ST_DONE;
      ST_DONE: if (i_host_start) w_state_nxt = ST_RST;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_rst_cnt     <= '0;
      r_cycle_count <= '0;
      r_timeout     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= w_rd_gnt;
      if (w_rd_gnt) r_rdata <= i_mem_rdata;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_host_start) begin
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_timeout     <= 1'b0;
          end
        end
        ST_RST: r_rst_cnt <= r_rst_cnt + 1'b1;
        ST_RUN: begin
          r_cycle_count <= w_count_inc;
          // A done in the same cycle as the limit is a normal completion.
          if (!i_core_done && w_limit) r_timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_host_gnt    = w_host_gnt;
  assign o_host_rvalid = r_rvalid;
  assign o_host_rdata  = r_rdata;
  assign o_core_rst    = (r_state == ST_IDLE) || (r_state == ST_RST);
  assign o_core_run    = (r_state == ST_RUN);
  assign o_busy        = (r_state == ST_RST) || (r_state == ST_RUN);
  assign o_finished    = (r_state == ST_DONE);
  assign o_timeout     = r_timeout;
  assign o_cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized directed runs of run_ctrl against a timeline and memory reference model.
`default_nettype none

module tb_run_ctrl;

  localparam int AW      = 8;
  localparam int CW      = 16;
  localparam int RST_CYC = 2;
  localparam int MAX_CYC = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           host_start = 1'b0;
  logic           host_req = 1'b0;
  logic           host_we = 1'b0;
  logic [AW-1:0]  host_addr = '0;
  logic [7:0]     host_wdata = '0;
  logic           host_gnt;
  logic           host_rvalid;
  logic [7:0]     host_rdata;
  logic           core_rst;
  logic           core_run;
  logic           core_done = 1'b0;
  logic           core_mem_we = 1'b0;
  logic [AW-1:0]  core_mem_addr = '0;
  logic [7:0]     core_mem_wdata = '0;
  logic           mem_we;
  logic [AW-1:0]  mem_addr;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_rdata;
  logic           busy;
  logic           finished;
  logic           timeout;
  logic [CW-1:0]  cycle_count;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  run_ctrl #(.AW(AW), .CW(CW), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_host_start     (host_start),
    .i_host_req       (host_req),
    .i_host_we        (host_we),
    .i_host_addr      (host_addr),
    .i_host_wdata     (host_wdata),
    .o_host_gnt       (host_gnt),
    .o_host_rvalid    (host_rvalid),
    .o_host_rdata     (host_rdata),
    .o_core_rst       (core_rst),
    .o_core_run       (core_run),
    .i_core_done      (core_done),
    .i_core_mem_we    (core_mem_we),
    .i_core_mem_addr  (core_mem_addr),
    .i_core_mem_wdata (core_mem_wdata),
    .o_mem_we         (mem_we),
    .o_mem_addr       (mem_addr),
    .o_mem_wdata      (mem_wdata),
    .i_mem_rdata      (mem_rdata),
    .o_busy           (busy),
    .o_finished       (finished),
    .o_timeout        (timeout),
    .o_cycle_count    (cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_core();
    core_mem_we    = 1'($urandom_range(0, 1));
    core_mem_addr  = 8'($urandom);
    core_mem_wdata = 8'($urandom);
  endtask

  // Expects host_req low so that the host grant is also at its idle value.
  task automatic chk_reset_vals(input string ph);
    chk({ph, ".core_rst"},    32'(core_rst),    32'd1);
    chk({ph, ".core_run"},    32'(core_run),    32'd0);
    chk({ph, ".host_gnt"},    32'(host_gnt),    32'd0);
    chk({ph, ".host_rvalid"}, 32'(host_rvalid), 32'd0);
    chk({ph, ".host_rdata"},  32'(host_rdata),  32'd0);
    chk({ph, ".busy"},        32'(busy),        32'd0);
    chk({ph, ".finished"},    32'(finished),    32'd0);
    chk({ph, ".timeout"},     32'(timeout),     32'd0);
    chk({ph, ".cycle_count"}, 32'(cycle_count), 32'd0);
    chk({ph, ".mem_we"},      32'(mem_we),      32'd0);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    rand_core();
    #1;
    chk("hw.gnt",   32'(host_gnt),  32'd1);
    chk("hw.we",    32'(mem_we),    32'd1);
    chk("hw.addr",  32'(mem_addr),  32'(a));
    chk("hw.wdata", 32'(mem_wdata), 32'(d));
    ref_mem[a] = d;
    tick();
    host_req = 1'b0;
  endtask

  // One complete run from IDLE or DONE; done_at = k means core_done in RUN cycle k, 0 means never.
  task automatic do_run(input int done_at, input bit host_during);
    bit          exp_to;
    int          len;
    logic [7:0]  ha, hd;
    exp_to = !(done_at >= 1 && done_at <= MAX_CYC);
    len    = exp_to ? MAX_CYC : done_at;
    ha     = 8'($urandom);
    hd     = 8'($urandom);
    host_start = 1'b1;
    rand_core();
    tick();
    host_start = 1'b0;
    if (host_during) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = ha; host_wdata = hd;
    end
    for (int r = 0; r < RST_CYC; r++) begin
      host_start = 1'($urandom_range(0, 1));
      rand_core();
      #1;
      chk("rst.core_rst", 32'(core_rst),    32'd1);
      chk("rst.core_run", 32'(core_run),    32'd0);
      chk("rst.busy",     32'(busy),        32'd1);
      chk("rst.finished", 32'(finished),    32'd0);
      chk("rst.timeout",  32'(timeout),     32'd0);
      chk("rst.count",    32'(cycle_count), 32'd0);
      chk("rst.mem_we",   32'(mem_we),      32'd0);
      chk("rst.gnt",      32'(host_gnt),    32'd0);
      tick();
    end
    for (int k = 1; k <= len; k++) begin
      host_start = 1'($urandom_range(0, 1));
      core_done  = (k == done_at);
      rand_core();
      #1;
      chk("run.core_run", 32'(core_run),    32'd1);
      chk("run.core_rst", 32'(core_rst),    32'd0);
      chk("run.busy",     32'(busy),        32'd1);
      chk("run.count",    32'(cycle_count), 32'(k - 1));
      chk("run.gnt",      32'(host_gnt),    32'd0);
      chk("run.mem_we",   32'(mem_we),      32'(core_mem_we));
      if (core_mem_we) begin
        chk("run.addr",  32'(mem_addr),  32'(core_mem_addr));
        chk("run.wdata", 32'(mem_wdata), 32'(core_mem_wdata));
        ref_mem[core_mem_addr] = core_mem_wdata;
      end
      tick();
    end
    host_start = 1'b0;
    core_done  = 1'b0;
    rand_core();
    #1;
    chk("done.finished", 32'(finished),    32'd1);
    chk("done.busy",     32'(busy),        32'd0);
    chk("done.core_run", 32'(core_run),    32'd0);
    chk("done.core_rst", 32'(core_rst),    32'd0);
    chk("done.count",    32'(cycle_count), 32'(len));
    chk("done.timeout",  32'(timeout),     32'(exp_to));
    chk("done.gnt",      32'(host_gnt),    32'(host_during));
    chk("done.mem_we",   32'(mem_we),      32'(host_during));
    if (host_during) begin
      chk("done.addr", 32'(mem_addr), 32'(ha));
      ref_mem[ha] = hd;
    end
    tick();
    host_req = 1'b0;
    rand_core();
    #1;
    chk("done2.count",  32'(cycle_count), 32'(len));
    chk("done2.mem_we", 32'(mem_we),      32'd0);
    tick();
  endtask

  initial begin
    // Reset held for three cycles with core stores being attempted.
    repeat (3) begin
      rand_core();
      @(negedge clk);
    end
    #1;
    chk_reset_vals("por");
    rst_n = 1'b1;
    #1;
    chk_reset_vals("idle");
    tick();

    host_write(8'h10, 8'hA5);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    #1;
    chk("rd.gnt", 32'(host_gnt), 32'd1);
    chk("rd.we",  32'(mem_we),   32'd0);
    tick();
    host_req = 1'b0;
    #1;
    chk("rd.rvalid", 32'(host_rvalid), 32'd1);
    chk("rd.rdata",  32'(host_rdata),  32'hA5);
    tick();
    chk("rd.rvalid_drop", 32'(host_rvalid), 32'd0);

    for (int i = 0; i < 256; i++) host_write(8'(i), 8'($urandom));

    do_run(5, 1'b1);
    do_run(0, 1'b0);
    do_run(MAX_CYC, 1'b1);
    do_run(MAX_CYC + 1, 1'b0);
    do_run(1, 1'b1);
    repeat (6) do_run(int'($urandom_range(0, 11)), 1'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a run.
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    repeat (RST_CYC) begin
      rand_core();
      tick();
    end
    for (int k = 1; k <= 3; k++) begin
      rand_core();
      #1;
      chk("mr.core_run", 32'(core_run),    32'd1);
      chk("mr.count",    32'(cycle_count), 32'(k - 1));
      if (core_mem_we) ref_mem[core_mem_addr] = core_mem_wdata;
      tick();
    end
    rand_core();
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun");
    tick();
    rst_n = 1'b1;
    #1;
    chk_reset_vals("after_mr");
    tick();
    do_run(3, 1'b0);

    for (int i = 0; i < 256; i++) begin
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'(i);
      rand_core();
      #1;
      chk("rb.gnt", 32'(host_gnt), 32'd1);
      chk("rb.we",  32'(mem_we),   32'd0);
      if (i > 0) begin
        chk("rb.rvalid", 32'(host_rvalid), 32'd1);
        chk("rb.rdata",  32'(host_rdata),  32'(ref_mem[i-1]));
      end
      tick();
    end
    host_req = 1'b0;
    #1;
    chk("rb.rvalid_last", 32'(host_rvalid), 32'd1);
    chk("rb.rdata_last",  32'(host_rdata),  32'(ref_mem[255]));
    tick();
    chk("rb.rvalid_end", 32'(host_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
